// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the CDB arbiter and its result FIFOs.
package cdb_arbiter_pkg;

    localparam int ROB_SIZE_WIDTH = 4;

    localparam logic CDB_SRC_ALU = 1'b0;
    localparam logic CDB_SRC_LSB = 1'b1;

    // A producer may sample the stall one cycle late, so one slot stays free.
    function automatic logic near_full(input int unsigned cnt,
                                       input int unsigned depth);
        return cnt >= depth - 1;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result FIFO: push/pop/flush with an occupancy count.
// Pushes into a full FIFO are dropped; flush wins over push and pop.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int W     = 36,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_din,
    output logic [W-1:0]  o_dout,
    output logic [AW:0]   o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && (r_count != (AW+1)'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_en) begin
            if (i_flush) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wr <= r_wr + 1'b1;
                if (w_pop)  r_rd <= r_rd + 1'b1;
                r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_en && !i_flush && w_push) r_mem[r_wr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one CDB between the ALU and the LSB.
// Define CDB_STATS_EN to add broadcast/conflict counters.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_W = ROB_SIZE_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rob_clear,
    input  logic             alu_valid,
    input  logic [ROB_W-1:0] alu_rob_id,
    input  logic [31:0]      alu_value,
    output logic             alu_stall,
    input  logic             lsb_valid,
    input  logic [ROB_W-1:0] lsb_rob_id,
    input  logic [31:0]      lsb_value,
    output logic             lsb_stall,
    output logic             cdb_valid,
    output logic [ROB_W-1:0] cdb_rob_id,
    output logic [31:0]      cdb_value,
    output logic             cdb_src
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]      stat_bcast,
    output logic [31:0]      stat_conflict
`endif
);

    localparam int W  = ROB_W + 32;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  w_alu_head;
    logic [W-1:0]  w_lsb_head;
    logic [W-1:0]  w_alu_in;
    logic [W-1:0]  w_lsb_in;
    logic [CW-1:0] w_alu_cnt;
    logic [CW-1:0] w_lsb_cnt;
    logic          w_alu_q;
    logic          w_lsb_q;
    logic          w_alu_cand;
    logic          w_lsb_cand;
    logic          w_both;
    logic          w_win_valid;
    logic          w_win_src;
    logic [W-1:0]  w_win_entry;
    logic          w_alu_byp;
    logic          w_lsb_byp;
    logic          w_alu_pop;
    logic          w_lsb_pop;
    logic          w_alu_push;
    logic          w_lsb_push;

    logic             r_last_grant;
    logic             r_cdb_valid;
    logic [ROB_W-1:0] r_cdb_rob_id;
    logic [31:0]      r_cdb_value;
    logic             r_cdb_src;

    assign w_alu_in = {alu_rob_id, alu_value};
    assign w_lsb_in = {lsb_rob_id, lsb_value};

    // Queued results take precedence over bypass to keep arrival order.
    assign w_alu_q    = (w_alu_cnt != '0);
    assign w_lsb_q    = (w_lsb_cnt != '0);
    assign w_alu_cand = w_alu_q | alu_valid;
    assign w_lsb_cand = w_lsb_q | lsb_valid;
    assign w_both     = w_alu_cand & w_lsb_cand;

    always_comb begin
        w_win_valid = w_alu_cand | w_lsb_cand;
        w_win_src   = CDB_SRC_ALU;
        if (w_both)
            w_win_src = ~r_last_grant;
        else if (w_lsb_cand)
            w_win_src = CDB_SRC_LSB;
        if (w_win_src == CDB_SRC_LSB)
            w_win_entry = w_lsb_q ? w_lsb_head : w_lsb_in;
        else
            w_win_entry = w_alu_q ? w_alu_head : w_alu_in;
    end

    assign w_alu_byp  = w_win_valid & (w_win_src == CDB_SRC_ALU) & ~w_alu_q;
    assign w_lsb_byp  = w_win_valid & (w_win_src == CDB_SRC_LSB) & ~w_lsb_q;
    assign w_alu_pop  = w_win_valid & (w_win_src == CDB_SRC_ALU) & w_alu_q;
    assign w_lsb_pop  = w_win_valid & (w_win_src == CDB_SRC_LSB) & w_lsb_q;
    assign w_alu_push = alu_valid & ~w_alu_byp;
    assign w_lsb_push = lsb_valid & ~w_lsb_byp;

    cdb_fifo #(.W(W), .DEPTH(DEPTH)) u_alu_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_en    (rdy),
        .i_flush (rob_clear),
        .i_push  (w_alu_push),
        .i_pop   (w_alu_pop),
        .i_din   (w_alu_in),
        .o_dout  (w_alu_head),
        .o_count (w_alu_cnt)
    );

    cdb_fifo #(.W(W), .DEPTH(DEPTH)) u_lsb_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_en    (rdy),
        .i_flush (rob_clear),
        .i_push  (w_lsb_push),
        .i_pop   (w_lsb_pop),
        .i_din   (w_lsb_in),
        .o_dout  (w_lsb_head),
        .o_count (w_lsb_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= CDB_SRC_LSB;
            r_cdb_valid  <= 1'b0;
            r_cdb_rob_id <= '0;
            r_cdb_value  <= '0;
            r_cdb_src    <= CDB_SRC_ALU;
        end else if (rdy) begin
            if (rob_clear) begin
                r_cdb_valid <= 1'b0;
            end else begin
                r_cdb_valid <= w_win_valid;
                if (w_win_valid) begin
                    r_cdb_rob_id <= w_win_entry[W-1:32];
                    r_cdb_value  <= w_win_entry[31:0];
                    r_cdb_src    <= w_win_src;
                end
                if (w_both) r_last_grant <= w_win_src;
            end
        end
    end

    assign alu_stall  = near_full(32'(w_alu_cnt), DEPTH);
    assign lsb_stall  = near_full(32'(w_lsb_cnt), DEPTH);
    assign cdb_valid  = r_cdb_valid;
    assign cdb_rob_id = r_cdb_rob_id;
    assign cdb_value  = r_cdb_value;
    assign cdb_src    = r_cdb_src;

`ifdef CDB_STATS_EN
    logic [31:0] r_bcast;
    logic [31:0] r_conflict;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcast    <= '0;
            r_conflict <= '0;
        end else if (rdy) begin
            if (r_cdb_valid) r_bcast <= r_bcast + 32'd1;
            if (w_both && !rob_clear) r_conflict <= r_conflict + 32'd1;
        end
    end

    assign stat_bcast    = r_bcast;
    assign stat_conflict = r_conflict;
`else
    // statistics counters are compiled out
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;

    localparam int ROB_W = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             rdy = 1'b1;
    logic             rob_clear = 1'b0;
    logic             alu_valid = 1'b0;
    logic [ROB_W-1:0] alu_rob_id = '0;
    logic [31:0]      alu_value = '0;
    logic             alu_stall;
    logic             lsb_valid = 1'b0;
    logic [ROB_W-1:0] lsb_rob_id = '0;
    logic [31:0]      lsb_value = '0;
    logic             lsb_stall;
    logic             cdb_valid;
    logic [ROB_W-1:0] cdb_rob_id;
    logic [31:0]      cdb_value;
    logic             cdb_src;
`ifdef CDB_STATS_EN
    logic [31:0]      stat_bcast;
    logic [31:0]      stat_conflict;
`endif

    always #5 clk = ~clk;

    cdb_arbiter #(.ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .rob_clear  (rob_clear),
        .alu_valid  (alu_valid),
        .alu_rob_id (alu_rob_id),
        .alu_value  (alu_value),
        .alu_stall  (alu_stall),
        .lsb_valid  (lsb_valid),
        .lsb_rob_id (lsb_rob_id),
        .lsb_value  (lsb_value),
        .lsb_stall  (lsb_stall),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_value  (cdb_value),
        .cdb_src    (cdb_src)
`ifdef CDB_STATS_EN
        ,
        .stat_bcast    (stat_bcast),
        .stat_conflict (stat_conflict)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [35:0] qa[$];
    logic [35:0] ql[$];
    bit          m_last;
    bit          m_valid;
    logic [3:0]  m_id;
    logic [31:0] m_val;
    bit          m_src;

    task automatic model_reset();
        qa.delete();
        ql.delete();
        m_last  = 1'b1;
        m_valid = 1'b0;
        m_id    = '0;
        m_val   = '0;
        m_src   = 1'b0;
    endtask

    // One arbitration step from the current inputs, applied at the next edge.
    task automatic model_tick();
        logic [35:0] ia, il, e;
        bit ac, lc, src, byp_a, byp_l;
        int na, nl;
        if (!rdy) return;
        if (rob_clear) begin
            qa.delete();
            ql.delete();
            m_valid = 1'b0;
            return;
        end
        ia = {alu_rob_id, alu_value};
        il = {lsb_rob_id, lsb_value};
        na = qa.size();
        nl = ql.size();
        ac = (na > 0) || alu_valid;
        lc = (nl > 0) || lsb_valid;
        byp_a = 1'b0;
        byp_l = 1'b0;
        e = '0;
        if (ac && lc) begin
            src = !m_last;
            m_last = src;
        end else begin
            src = lc;
        end
        if (ac || lc) begin
            if (!src) begin
                if (na > 0) e = qa.pop_front();
                else begin e = ia; byp_a = 1'b1; end
            end else begin
                if (nl > 0) e = ql.pop_front();
                else begin e = il; byp_l = 1'b1; end
            end
            m_valid = 1'b1;
            m_id = e[35:32];
            m_val = e[31:0];
            m_src = src;
        end else begin
            m_valid = 1'b0;
        end
        if (alu_valid && !byp_a) begin
            chk("ovf_alu", 64'(na == DEPTH), 64'(0));
            if (na < DEPTH) qa.push_back(ia);
        end
        if (lsb_valid && !byp_l) begin
            chk("ovf_lsb", 64'(nl == DEPTH), 64'(0));
            if (nl < DEPTH) ql.push_back(il);
        end
    endtask

    task automatic cyc();
        model_tick();
        @(posedge clk);
        #1;
        chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        chk("cdb_rob_id", 64'(cdb_rob_id), 64'(m_id));
        chk("cdb_value", 64'(cdb_value), 64'(m_val));
        chk("cdb_src", 64'(cdb_src), 64'(m_src));
        chk("alu_stall", 64'(alu_stall), 64'(qa.size() >= DEPTH - 1));
        chk("lsb_stall", 64'(lsb_stall), 64'(ql.size() >= DEPTH - 1));
    endtask

    task automatic drv(input bit av, input logic [3:0] aid,
                       input logic [31:0] aval, input bit lv,
                       input logic [3:0] lid, input logic [31:0] lval);
        alu_valid  = av;
        alu_rob_id = aid;
        alu_value  = aval;
        lsb_valid  = lv;
        lsb_rob_id = lid;
        lsb_value  = lval;
    endtask

    task automatic idle();
        drv(0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
    endtask

    logic [4:0] got[$];
    logic [4:0] cexp [6];
    bit pa, pl, saw;
    bit s_alu, s_lsb;

    initial begin
        cexp = '{5'h01, 5'h15, 5'h02, 5'h16, 5'h03, 5'h17};
        model_reset();
        idle();
        #12 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", 64'(cdb_valid), 64'(0));
        chk("rst_id", 64'(cdb_rob_id), 64'(0));
        repeat (3) cyc();

        // reset asserted while a broadcast is on the bus
        drv(1, 4'h9, 32'hdead, 0, 4'd0, 32'd0);
        cyc();
        idle();
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", 64'(cdb_valid), 64'(0));
        chk("async_rst_value", 64'(cdb_value), 64'(0));
        #1 rst = 1'b1;
        repeat (2) cyc();

        // lone ALU result
        drv(1, 4'd3, 32'h1234, 0, 4'd0, 32'd0);
        cyc();
        chk("lone_valid", 64'(cdb_valid), 64'(1));
        chk("lone_id", 64'(cdb_rob_id), 64'(3));
        chk("lone_value", 64'(cdb_value), 64'(32'h1234));
        chk("lone_src", 64'(cdb_src), 64'(0));
        chk("lone_stall", 64'(alu_stall), 64'(0));
        idle();
        cyc();
        chk("lone_after", 64'(cdb_valid), 64'(0));

        // contention
        got.delete();
        for (int i = 0; i < 9; i++) begin
            if (i < 3)
                drv(1, 4'(i + 1), 32'(100 + i), 1, 4'(i + 5), 32'(200 + i));
            else
                idle();
            cyc();
            if (cdb_valid) got.push_back({cdb_src, cdb_rob_id});
        end
        chk("cont_count", 64'(got.size()), 64'(6));
        for (int i = 0; i < 6 && i < got.size(); i++)
            chk($sformatf("cont_order%0d", i), 64'(got[i]), 64'(cexp[i]));

        // backpressure with late-sampled stalls
        pa = 0; pl = 0; saw = 0;
        for (int i = 0; i < 16; i++) begin
            drv(!pa, 4'(i), 32'(i), !pl, 4'(i + 8), 32'(i + 16));
            pa = alu_stall;
            pl = lsb_stall;
            cyc();
            if (lsb_stall) saw = 1;
        end
        chk("bp_stall_seen", 64'(saw), 64'(1));
        idle();
        repeat (12) cyc();
        chk("bp_drained", 64'(cdb_valid), 64'(0));

        // flush with queued entries and live inputs
        drv(1, 4'h1, 32'h11, 1, 4'h2, 32'h22);
        cyc();
        drv(1, 4'h3, 32'h33, 1, 4'h4, 32'h44);
        cyc();
        rob_clear = 1'b1;
        drv(1, 4'ha, 32'haa, 1, 4'hb, 32'hbb);
        cyc();
        rob_clear = 1'b0;
        chk("flush_valid", 64'(cdb_valid), 64'(0));
        chk("flush_astall", 64'(alu_stall), 64'(0));
        chk("flush_lstall", 64'(lsb_stall), 64'(0));
        idle();
        repeat (4) cyc();

        // freeze with non-empty FIFOs
        for (int i = 0; i < 3; i++) begin
            drv(1, 4'(i), 32'(i + 40), 1, 4'(i + 4), 32'(i + 50));
            cyc();
        end
        idle();
        s_alu = alu_stall;
        s_lsb = lsb_stall;
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv(1, 4'hf, $urandom, 1, 4'he, $urandom);
            cyc();
        end
        chk("frz_astall", 64'(alu_stall), 64'(s_alu));
        chk("frz_lstall", 64'(lsb_stall), 64'(s_lsb));
        rdy = 1'b1;
        idle();
        repeat (8) cyc();

        // randomized traffic
        pa = 0; pl = 0;
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 9) != 0);
            rob_clear = ($urandom_range(0, 39) == 0);
            drv(($urandom & 1) && !pa, 4'($urandom), $urandom,
                ($urandom & 1) && !pl, 4'($urandom), $urandom);
            pa = alu_stall;
            pl = lsb_stall;
            cyc();
        end
        rdy = 1'b1;
        rob_clear = 1'b0;
        idle();
        repeat (10) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
